// File: rtl/synth_pkg.sv
// Shared envelope definitions: level width, FSM state encoding and small helpers.
// The DECAY code is always defined here; only note_envelope decides whether to use it.
package synth_pkg;

   localparam int ENV_W = 8;
   localparam logic [ENV_W-1:0] ENV_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pwm_dac.sv
// Free-running 8-bit PWM DAC: the output is high while the counter is below the level,
// gated by enable. The output is registered, so it lags enable by one cycle.
module pwm_dac
   import synth_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ENV_W-1:0] level,
   input  logic             enable,
   output logic             pwm
);

   logic [ENV_W-1:0] pwm_cnt;

   // Level 0 can never exceed the counter, so the output stays at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         pwm     <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         pwm     <= enable && (pwm_cnt < level);
      end
   end

endmodule

// File: rtl/note_envelope.sv
// Note envelope generator (ADSR-style) that amplitude-modulates the keyboard tone.
// Define ENVELOPE_DECAY_EN to add the DECAY stage, which falls toward sustain_level.
module note_envelope
   import synth_pkg::*;
#(
   parameter int CLK_HZ           = 25_000_000,
   parameter int ATTACK_STEP_CYC  = 25_000,
   parameter int RELEASE_STEP_CYC = 50_000,
   parameter int DECAY_STEP_CYC   = 50_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gate,
   input  logic             tone_in,
   input  logic [ENV_W-1:0] sustain_level,
   output logic             audio_pwm,
   output logic [ENV_W-1:0] env_level,
   output logic [2:0]       env_state,
   output logic             busy
);

   localparam int MAX_STEP = max3(ATTACK_STEP_CYC, RELEASE_STEP_CYC, DECAY_STEP_CYC);
   localparam int CNT_W    = $clog2(MAX_STEP + 1);

`ifdef ENVELOPE_DECAY_EN
   localparam env_state_t PEAK_NEXT = ST_DECAY;
   logic unused_cfg;
   assign unused_cfg = ^32'(CLK_HZ);
`else
   localparam env_state_t PEAK_NEXT = ST_SUSTAIN;
   logic unused_cfg;
   assign unused_cfg = ^{sustain_level, 32'(CLK_HZ)};
`endif

   env_state_t       state;
   logic [CNT_W-1:0] step_cnt;
   logic             step_last;

   always_comb begin
      step_last = 1'b0;
      case (state)
         ST_ATTACK:  step_last = (step_cnt == CNT_W'(ATTACK_STEP_CYC - 1));
         ST_RELEASE: step_last = (step_cnt == CNT_W'(RELEASE_STEP_CYC - 1));
`ifdef ENVELOPE_DECAY_EN
         ST_DECAY:   step_last = (step_cnt == CNT_W'(DECAY_STEP_CYC - 1));
`endif
         default:    step_last = 1'b0;
      endcase
   end

   // Any state change also clears step_cnt; those later NBAs override the default count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         env_level <= '0;
         step_cnt  <= '0;
         busy      <= 1'b0;
      end else begin
         step_cnt <= step_last ? '0 : step_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               step_cnt <= '0;
               if (gate) begin
                  state <= ST_ATTACK;
                  busy  <= 1'b1;
               end
            end

            ST_ATTACK: begin
               if (!gate) begin
                  state    <= ST_RELEASE;
                  step_cnt <= '0;
               end else if (env_level == ENV_MAX) begin
                  // Retriggered from RELEASE while still at the peak.
                  state    <= PEAK_NEXT;
                  step_cnt <= '0;
               end else if (step_last) begin
                  env_level <= env_level + 1'b1;
                  if (env_level == ENV_MAX - 8'd1)
                     state <= PEAK_NEXT;
               end
            end

`ifdef ENVELOPE_DECAY_EN
            ST_DECAY: begin
               if (!gate) begin
                  state    <= ST_RELEASE;
                  step_cnt <= '0;
               end else if (env_level <= sustain_level) begin
                  state    <= ST_SUSTAIN;
                  step_cnt <= '0;
               end else if (step_last) begin
                  env_level <= env_level - 1'b1;
                  if (env_level - 8'd1 == sustain_level)
                     state <= ST_SUSTAIN;
               end
            end
`endif

            ST_SUSTAIN: begin
               if (!gate) begin
                  state    <= ST_RELEASE;
                  step_cnt <= '0;
               end
            end

            ST_RELEASE: begin
               if (gate) begin
                  state    <= ST_ATTACK;
                  step_cnt <= '0;
               end else if (env_level == '0) begin
                  state    <= ST_IDLE;
                  step_cnt <= '0;
                  busy     <= 1'b0;
               end else if (step_last) begin
                  env_level <= env_level - 1'b1;
                  if (env_level == 8'd1) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               step_cnt <= '0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   assign env_state = state;

   pwm_dac u_dac (
      .clk    (clk),
      .rst_n  (rst_n),
      .level  (env_level),
      .enable (tone_in),
      .pwm    (audio_pwm)
   );

endmodule

// File: tb/tb_note_envelope.sv
// Bench for note_envelope: directed envelope timing, PWM duty, async reset, then random
// gate/tone traffic, each cycle compared against a behavioural model of the envelope.
module tb_note_envelope;

   localparam int ATT = 4;
   localparam int REL = 8;
   localparam int DEC = 2;
`ifdef ENVELOPE_DECAY_EN
   localparam int PEAK_NEXT = 2;
   localparam int SUS1      = 128;
   localparam int R35_L     = 200;
`else
   localparam int PEAK_NEXT = 3;
   localparam int SUS1      = 255;
   localparam int R35_L     = 255;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       gate = 1'b0;
   logic       tone_in = 1'b0;
   logic [7:0] sustain_level = 8'd255;
   logic       audio_pwm;
   logic [7:0] env_level;
   logic [2:0] env_state;
   logic       busy;

   note_envelope #(
      .CLK_HZ           (25_000_000),
      .ATTACK_STEP_CYC  (ATT),
      .RELEASE_STEP_CYC (REL),
      .DECAY_STEP_CYC   (DEC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gate          (gate),
      .tone_in       (tone_in),
      .sustain_level (sustain_level),
      .audio_pwm     (audio_pwm),
      .env_level     (env_level),
      .env_state     (env_state),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: state number, level, cycles into the current step, DAC count.
   int m_state, m_level, m_elapsed, m_cnt;
   bit m_pwm;

   task automatic model_reset();
      m_state = 0; m_level = 0; m_elapsed = 0; m_cnt = 0; m_pwm = 0;
   endtask

   task automatic go(input int s);
      m_state   = s;
      m_elapsed = 0;
   endtask

   task automatic model_edge();
      int sus;
      sus   = int'(sustain_level);
      m_pwm = tone_in && (m_cnt < m_level);
      m_cnt = (m_cnt + 1) % 256;
      case (m_state)
         0: if (gate) go(1);
         1: begin
            if (!gate) go(4);
            else if (m_level == 255) go(PEAK_NEXT);
            else begin
               m_elapsed++;
               if (m_elapsed == ATT) begin
                  m_elapsed = 0;
                  m_level++;
                  if (m_level == 255) go(PEAK_NEXT);
               end
            end
         end
         2: begin
            if (!gate) go(4);
            else if (m_level <= sus) go(3);
            else begin
               m_elapsed++;
               if (m_elapsed == DEC) begin
                  m_elapsed = 0;
                  m_level--;
                  if (m_level <= sus) go(3);
               end
            end
         end
         3: if (!gate) go(4);
         4: begin
            if (gate) go(1);
            else if (m_level == 0) go(0);
            else begin
               m_elapsed++;
               if (m_elapsed == REL) begin
                  m_elapsed = 0;
                  m_level--;
                  if (m_level == 0) go(0);
               end
            end
         end
         default: go(0);
      endcase
   endtask

   // One clock: advance the model at the edge, compare everything on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("cycle", 32'({env_state, env_level, busy, audio_pwm}),
          32'({3'(m_state), 8'(m_level), m_state != 0, m_pwm}));
   endtask

   task automatic duty_test(input int exp_high);
      int highs;
      tone_in = 1'b1;
      tick();
      highs = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         highs += int'(audio_pwm);
      end
      chk("duty_on", 32'(highs), 32'(exp_high));
      tone_in = 1'b0;
      tick();
      highs = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         highs += int'(audio_pwm);
      end
      chk("duty_off", 32'(highs), 32'd0);
   endtask

   initial begin
      int hold;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_out", 32'({env_state, env_level, busy, audio_pwm}), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();

`ifdef ENVELOPE_DECAY_EN
      sustain_level = 8'd128;
`endif
      // Attack from IDLE: 255 steps of ATT cycles after the entry edge.
      gate = 1'b1;
      tick();
      chk("att_entry", 32'(env_state), 32'd1);
      repeat (255 * ATT - 1) tick();
      chk("att_254_lvl", 32'(env_level), 32'd254);
      chk("att_254_st", 32'(env_state), 32'd1);
      tick();
      chk("peak_lvl", 32'(env_level), 32'd255);
      chk("peak_st", 32'(env_state), 32'(PEAK_NEXT));
`ifdef ENVELOPE_DECAY_EN
      repeat ((255 - 128) * DEC - 1) tick();
      chk("decay_129", 32'({env_state, env_level}), 32'({3'd2, 8'd129}));
      tick();
      chk("decay_done", 32'({env_state, env_level}), 32'({3'd3, 8'd128}));
`endif
      duty_test(SUS1);

      // Release from the sustain level down to IDLE.
      gate = 1'b0;
      tick();
      chk("rel_entry", 32'({env_state, env_level}), 32'({3'd4, 8'(SUS1)}));
      repeat (REL * SUS1 - 1) tick();
      chk("rel_last", 32'({env_state, env_level, busy}), 32'({3'd4, 8'd1, 1'b1}));
      tick();
      chk("rel_idle", 32'({env_state, env_level, busy}), 32'd0);

`ifdef ENVELOPE_DECAY_EN
      sustain_level = 8'd64;
      gate = 1'b1;
      repeat (1 + 255 * ATT + 191 * DEC) tick();
      chk("sus64", 32'({env_state, env_level}), 32'({3'd3, 8'd64}));
      duty_test(64);
      gate = 1'b0;
      repeat (64 * REL + 1) tick();
      chk("sus64_idle", 32'(env_state), 32'd0);
      sustain_level = 8'd200;
`endif

      // Retrigger during RELEASE at level 100.
      gate = 1'b1;
      for (int i = 0; i < 3000 && m_state != 3; i++) tick();
      chk("r35_sus", 32'({env_state, env_level}), 32'({3'd3, 8'(R35_L)}));
      gate = 1'b0;
      tick();
      repeat ((R35_L - 100) * REL) tick();
      chk("r35_100", 32'({env_state, env_level}), 32'({3'd4, 8'd100}));
      gate = 1'b1;
      tick();
      chk("r35_att", 32'({env_state, env_level}), 32'({3'd1, 8'd100}));
      repeat (ATT - 1) tick();
      chk("r35_hold", 32'(env_level), 32'd100);
      tick();
      chk("r35_101", 32'(env_level), 32'd101);
      repeat (ATT) tick();
      chk("r35_102", 32'(env_level), 32'd102);

      // Asynchronous reset in the middle of ATTACK, checked before any clock edge.
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(env_state), 32'd0);
      chk("arst_level", 32'(env_level), 32'd0);
      chk("arst_busy_pwm", 32'({busy, audio_pwm}), 32'd0);
      model_reset();
      gate = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("arst_idle", 32'(env_state), 32'd0);

      // Random gate/tone traffic with a mix of short glitches and long holds.
      for (int s = 0; s < 30; s++) begin
         gate = 1'($urandom % 2);
         hold = ($urandom % 4 == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(20, 1500));
`ifdef ENVELOPE_DECAY_EN
         sustain_level = 8'($urandom);
`endif
         for (int c = 0; c < hold; c++) begin
            tone_in = 1'($urandom % 2);
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
